// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/CS_N/MOSI in the clk domain, presents received words on a
// strobe interface and transmits words taken from a one-entry valid/ready holding buffer.
module spi_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_undr,
    output logic                  busy
);
    localparam int unsigned    CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CS} state_e;

    state_e state_q, state_d;

    // [0]=first sync, [1]=second sync, [2]=history for edge detection
    logic [2:0] sck_q, cs_q;
    logic [1:0] mosi_q;

    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-2:0] rx_sr_q;
    logic [DATA_WIDTH-1:0] rx_data_q, tx_q, buf_q;
    logic                  rx_valid_q, tx_undr_q, buf_full_q;

    logic sck_edge, leading, trailing, sample_edge, shift_edge;
    logic cs_fall, cs_low;
    logic active, load_en, shift_en, sample_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= {3{CPOL}};
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck_i};
            cs_q   <= {cs_q[1:0], spi_cs_n_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
        end
    end

    assign sck_edge    = sck_q[1] ^ sck_q[2];
    assign leading     = sck_edge & (sck_q[1] != CPOL);
    assign trailing    = sck_edge & (sck_q[1] == CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading : trailing;
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign cs_low      = ~cs_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // CS already low with no falling edge seen can only mean we woke up mid-frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall)      state_d = ACTIVE;
                     else if (cs_low)  state_d = WAIT_CS;
            ACTIVE:  if (!cs_low)      state_d = IDLE;
            WAIT_CS: if (!cs_low)      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        active    = (state_q == ACTIVE);
        load_en   = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        if (state_q == IDLE) begin
            load_en = cs_fall & ~CPHA;
        end else if (active && cs_low) begin
            sample_en = sample_edge;
            load_en   = shift_edge & (cnt_q == '0);
            shift_en  = shift_edge & (cnt_q != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_q       <= '0;
            tx_undr_q  <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_undr_q  <= 1'b0;

            if (!active || !cs_low)
                cnt_q <= '0;
            else if (sample_en)
                cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

            if (sample_en) begin
                rx_sr_q <= {rx_sr_q[DATA_WIDTH-3:0], mosi_q[1]};
                if (cnt_q == LAST) begin
                    rx_data_q  <= {rx_sr_q, mosi_q[1]};
                    rx_valid_q <= 1'b1;
                end
            end

            if (load_en) begin
                if (buf_full_q) begin
                    tx_q <= buf_q;
                end else begin
                    tx_q      <= '0;
                    tx_undr_q <= 1'b1;
                end
            end else if (shift_en) begin
                tx_q <= tx_q << 1;
            end else if (active && !cs_low) begin
                tx_q <= '0;
            end

            // a write racing an underrun load is kept for the next load, never bypassed
            if (load_en && buf_full_q) begin
                buf_full_q <= 1'b0;
            end else if (tx_valid && !buf_full_q) begin
                buf_q      <= tx_data;
                buf_full_q <= 1'b1;
            end
        end
    end

    assign spi_miso_o    = active & tx_q[DATA_WIDTH-1];
    assign spi_miso_oe_o = active;
    assign busy          = active;
    assign tx_ready      = ~buf_full_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign tx_undr       = tx_undr_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance driven by a bit-level SPI master,
// checked against a word-level model of the holding buffer and load points.
module tb_spi_slave;
    localparam int HP = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] sck = 2'b10, csn = 2'b11, mosi = 2'b00, txv = 2'b00;
    logic [1:0][7:0] txd = '0;
    logic [1:0] miso, oe, txr, rxv, undr, busy;
    logic [1:0][7:0] rxd;

    int checks = 0, failures = 0;
    bit [1:0] bfull_m = 2'b00;
    logic [1:0][7:0] bval_m = '0;
    int exp_undr [2] = '{0, 0};
    int undr_cnt [2] = '{0, 0};
    logic [7:0] mw [4];
    bit rf_en [4];
    logic [7:0] rf_val [4];
    logic [7:0] exp_miso [$];
    logic [8:0] exp_rx [$];

    always #5 clk = ~clk;

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .rst(rst), .spi_sck_i(sck[0]), .spi_cs_n_i(csn[0]), .spi_mosi_i(mosi[0]),
        .spi_miso_o(miso[0]), .spi_miso_oe_o(oe[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
        .tx_ready(txr[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]), .tx_undr(undr[0]), .busy(busy[0]));

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .rst(rst), .spi_sck_i(sck[1]), .spi_cs_n_i(csn[1]), .spi_mosi_i(mosi[1]),
        .spi_miso_o(miso[1]), .spi_miso_oe_o(oe[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
        .tx_ready(txr[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]), .tx_undr(undr[1]), .busy(busy[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // rx monitor: pops the scoreboard on every rx_valid strobe
    always @(negedge clk) begin
        if (rst) begin
            undr_cnt[0] = 0;
            undr_cnt[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (undr[d]) undr_cnt[d]++;
                if (rxv[d]) begin
                    if (exp_rx.size() == 0) chk("rx_valid_unexpected", 32'(rxv[d]), 32'd0);
                    else chk("rx_data", 32'({d[0], rxd[d]}), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (HP) @(posedge clk);
        #2;
    endtask

    // Model of one load: the word the slave will shift out next
    task automatic model_load(input int d);
        if (bfull_m[d]) begin
            exp_miso.push_back(bval_m[d]);
            bfull_m[d] = 1'b0;
        end else begin
            exp_miso.push_back(8'h00);
            exp_undr[d]++;
        end
    endtask

    task automatic wr(input int d, input logic [7:0] v);
        chk("tx_ready_before_write", 32'(txr[d]), 32'(!bfull_m[d]));
        txd[d] = v;
        txv[d] = 1'b1;
        @(posedge clk);
        #2;
        txv[d] = 1'b0;
        bval_m[d]  = v;
        bfull_m[d] = 1'b1;
    endtask

    task automatic clr_rf();
        for (int i = 0; i < 4; i++) rf_en[i] = 1'b0;
    endtask

    // d=0: CPOL0/CPHA0, d=1: CPOL1/CPHA1. nab>0 aborts word 0 after nab bits.
    task automatic frame(input int d, input int nw, input int nab);
        logic [7:0] got;
        bit ab;
        ab = 1'b0;
        exp_miso.delete();
        csn[d] = 1'b0;
        if (d == 0) begin
            model_load(0);
            mosi[0] = mw[0][7];
        end
        half(); half();
        for (int w = 0; w < nw && !ab; w++) begin
            got = '0;
            if (!(w == 0 && nab > 0)) exp_rx.push_back({d[0], mw[w]});
            for (int b = 0; b < 8; b++) begin
                if (w == 0 && nab > 0 && b == nab) begin
                    ab = 1'b1;
                    break;
                end
                if (b == 2 && rf_en[w] && !bfull_m[d]) wr(d, rf_val[w]);
                if (b == 4) begin
                    chk("busy_mid", 32'(busy[d]), 32'd1);
                    chk("miso_oe_mid", 32'(oe[d]), 32'd1);
                    chk("tx_ready_mid", 32'(txr[d]), 32'(!bfull_m[d]));
                end
                if (d == 0) begin
                    got = {got[6:0], miso[0]};
                    sck[0] = 1'b1;
                    half();
                    sck[0] = 1'b0;
                    if (b == 7) begin
                        model_load(0);
                        mosi[0] = (w + 1 < nw) ? mw[w+1][7] : 1'b0;
                    end else begin
                        mosi[0] = mw[w][6-b];
                    end
                    half();
                end else begin
                    if (b == 0) model_load(1);
                    sck[1] = 1'b0;
                    mosi[1] = mw[w][7-b];
                    half();
                    got = {got[6:0], miso[1]};
                    sck[1] = 1'b1;
                    half();
                end
            end
            if (!ab) begin
                if (exp_miso.size() == 0) chk("miso_word_missing", 32'(got), 32'hFFFF);
                else chk("miso_word", 32'(got), 32'(exp_miso.pop_front()));
            end
        end
        half();
        csn[d] = 1'b1;
        half(); half();
        chk("busy_after", 32'(busy[d]), 32'd0);
        chk("miso_oe_after", 32'(oe[d]), 32'd0);
        chk("miso_after", 32'(miso[d]), 32'd0);
        chk("tx_undr_count", 32'(undr_cnt[d]), 32'(exp_undr[d]));
        chk("rx_words_outstanding", 32'(exp_rx.size()), 32'd0);
        exp_rx.delete();
        exp_miso.delete();
    endtask

    task automatic chk_reset_vals();
        for (int d = 0; d < 2; d++)
            chk("reset_values", 32'({miso[d], oe[d], txr[d], rxd[d], rxv[d], undr[d], busy[d]}),
                32'({1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
    endtask

    initial begin
        int d, nw;
        clr_rf();
        repeat (3) @(posedge clk);
        #2;
        chk_reset_vals();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;

        // mode 0 single word
        wr(0, 8'hA5); mw[0] = 8'h3C; frame(0, 1, 0);
        // back-to-back words with a refill during the first
        wr(0, 8'hA5); mw[0] = 8'h01; mw[1] = 8'h80;
        rf_en[0] = 1'b1; rf_val[0] = 8'h5A;
        frame(0, 2, 0);
        clr_rf();
        // underrun from the first load
        mw[0] = 8'($urandom); frame(0, 1, 0);
        // abort after 3 bits, then a clean frame
        if (!bfull_m[0]) wr(0, 8'($urandom));
        mw[0] = 8'($urandom); frame(0, 1, 3);
        mw[0] = 8'hC3; frame(0, 1, 0);
        // mode 3 instance
        wr(1, 8'h96); mw[0] = 8'h69; frame(1, 1, 0);

        repeat (24) begin
            d  = int'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) begin
                mw[i]     = 8'($urandom);
                rf_en[i]  = 1'($urandom_range(0, 1));
                rf_val[i] = 8'($urandom);
            end
            if ($urandom_range(0, 3) != 0 && !bfull_m[d]) wr(d, 8'($urandom));
            frame(d, nw, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0);
        end
        clr_rf();

        // reset mid-frame with CS held low
        csn[0] = 1'b0; mosi[0] = 1'b1;
        half(); half();
        sck[0] = 1'b1; half(); sck[0] = 1'b0; half();
        rst = 1'b1;
        bfull_m = 2'b00; exp_undr[0] = 0; exp_undr[1] = 0;
        exp_rx.delete(); exp_miso.delete();
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        for (int b = 0; b < 8; b++) begin
            mosi[0] = 1'($urandom);
            sck[0] = 1'b1; half(); sck[0] = 1'b0; half();
        end
        chk("busy_wait_cs", 32'(busy[0]), 32'd0);
        chk("miso_oe_wait_cs", 32'(oe[0]), 32'd0);
        csn[0] = 1'b1;
        half(); half();
        wr(0, 8'h3A); mw[0] = 8'($urandom); frame(0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
